player_pose_ctrl: RTL and testbench
===================================

// Module: player_pose_ctrl
// PURPOSE
//  Per-player fighter controller that drives the sprite renderer's inputs: pose flags, sprite origin, flip and health.
//  Takes debounced button levels and a per-frame tick; runs pose FSM, walk/jump motion, attack timers, damage/death.
//  One instance per player; outputs are registered and stable for a whole frame.
// PARAMETERS
//  START_X       10'd64   spritex after reset
//  GROUND_Y      10'd300  spritey when grounded
//  X_MIN         10'd0    left clamp for spritex
//  X_MAX         10'd512  right clamp for spritex (640 - 128 px sprite width)
//  WALK_STEP     4'd3     px per frame tick when walking or airborne
//  JUMP_V0       6'd14    initial upward speed (px/tick)
//  GRAVITY       3'd1     added to vertical velocity each tick
//  PUNCH_TICKS   5'd8     frame ticks in PUNCH / CROUCHPUNCH
//  KICK_TICKS    5'd12    frame ticks in KICK
//  HEALTH_MAX    8'd100   health after reset
// PORTS
//  vga_clk      in   1   sole clock
//  reset        in   1   synchronous, active-high
//  frame_tick   in   1   1-cycle pulse per frame; all motion/FSM steps occur only on it
//  btn_left/btn_right/btn_up/btn_down  in 1 each  direction levels
//  btn_punch/btn_kick/btn_block        in 1 each  action levels
//  opponent_x   in   10  opponent spritex, used for facing
//  hit_valid    in   1   1-cycle pulse: opponent attack connected
//  hit_damage   in   8   damage carried with hit_valid
//  spritex, spritey          out 10  sprite origin
//  stand, crouch, jump, kick, punch, crouchpunch, move, block, dead, flip  out 1  renderer pose flags
//  health       out  8   remaining health
// BEHAVIOUR
//  Reset: state IDLE, spritex=START_X, spritey=GROUND_Y, vy=0, timer=0, health=HEALTH_MAX, flip=1,
//   stand=1, all other flags 0. Reset mid-jump/attack/dead returns here on the next edge.
//  States and flags: IDLE{stand}, WALK{stand,move}, CROUCH{crouch}, JUMP{jump}, PUNCH{punch},
//   KICK{kick}, CPUNCH{crouchpunch}, BLOCK{block}, DEAD{dead}. Exactly the listed flags are high.
//  Flags/position update 1 cycle after the frame_tick edge; no change between ticks except health/dead.
//  Decision in IDLE/WALK/CROUCH/BLOCK on tick, first match wins:
//   up->JUMP (vy=-JUMP_V0); punch&down->CPUNCH; punch->PUNCH; kick->KICK; down->CROUCH;
//   block->BLOCK; left XOR right->WALK; else IDLE. left&right together = neither.
//  WALK: spritex -=/+= WALK_STEP, saturating at X_MIN/X_MAX (no wrap; 10-bit underflow forbidden).
//  JUMP: each tick spritey+=vy (signed 7-bit), vy+=GRAVITY; left/right move as in WALK.
//   If spritey+vy >= GROUND_Y: spritey=GROUND_Y, vy=0, state IDLE on that tick. Buttons ignored otherwise.
//  PUNCH/CPUNCH/KICK: timer loads *_TICKS-1 on entry, decrements per tick; at 0 -> IDLE next tick.
//   Held buttons do not retrigger until after return to IDLE.
//  flip: updated on tick in grounded non-attack states only; flip=1 iff opponent_x >= spritex.
//  Damage: on hit_valid (any cycle, not gated by tick): dmg = BLOCK ? hit_damage>>2 : hit_damage;
//   health = (dmg >= health) ? 0 : health-dmg. health==0 -> DEAD next cycle, overriding any state.
//  DEAD: sticky until reset; hits and buttons ignored; spritey forced to GROUND_Y on next tick.
//  hit_valid coincident with frame_tick: damage applied and FSM step both happen; DEAD wins.
// CONFIGURATION
//  PLAYER_AIR_KICK_EN defined: btn_kick in JUMP asserts kick together with jump for KICK_TICKS ticks
//   (renderer shows kick pose); physics continue; landing clears kick and timer.
//  Undefined: btn_kick ignored while airborne; kick never high with jump.
// TESTING
//  Reset, 5 ticks no buttons -> stand=1 only, spritex=64, spritey=300, health=100, flip=1 (opponent_x=400).
//  btn_right held 200 ticks from spritex=500 -> move&stand, spritex 503,506,509,512 then holds 512.
//  btn_up 1 tick -> jump=1, spritey 286,273,... apex, lands at 300 after 29 ticks, then stand=1.
//  btn_punch held 20 ticks -> punch high exactly 8 ticks, then IDLE, no retrigger until release.
//  BLOCK, hit_valid dmg=40 -> health 90; IDLE, hit dmg=200 -> health 0, dead=1, stays through buttons.
//  AIR_KICK_EN: btn_kick at tick 3 of jump -> jump&kick 12 ticks or until landing; without macro kick=0.

Source files
------------

// File: rtl/player_pose_ctrl.sv
// player_pose_ctrl: per-player fighter controller feeding the sprite renderer.
// Runs the pose FSM, walk/jump motion, attack timers and damage/death on frame ticks.
// Optional feature macro: PLAYER_AIR_KICK_EN enables a kick pose during a jump.
module player_pose_ctrl #(
    parameter logic [9:0] START_X     = 10'd64,
    parameter logic [9:0] GROUND_Y    = 10'd300,
    parameter logic [9:0] X_MIN       = 10'd0,
    parameter logic [9:0] X_MAX       = 10'd512,
    parameter logic [3:0] WALK_STEP   = 4'd3,
    parameter logic [5:0] JUMP_V0     = 6'd14,
    parameter logic [2:0] GRAVITY     = 3'd1,
    parameter logic [4:0] PUNCH_TICKS = 5'd8,
    parameter logic [4:0] KICK_TICKS  = 5'd12,
    parameter logic [7:0] HEALTH_MAX  = 8'd100
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       btn_block,
    input  logic [9:0] opponent_x,
    input  logic       hit_valid,
    input  logic [7:0] hit_damage,
    output logic [9:0] spritex,
    output logic [9:0] spritey,
    output logic       stand,
    output logic       crouch,
    output logic       jump,
    output logic       kick,
    output logic       punch,
    output logic       crouchpunch,
    output logic       move,
    output logic       block,
    output logic       dead,
    output logic       flip,
    output logic [7:0] health
);

    typedef enum logic [3:0] {
        S_IDLE, S_WALK, S_CROUCH, S_JUMP, S_PUNCH, S_KICK, S_CPUNCH, S_BLOCK, S_DEAD
    } state_t;

    // Pose vector layout: {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead}
    localparam logic [8:0] POSE_RESET = 9'b1_0000_0000;

    state_t             r_state;
    state_t             w_next_state;
    state_t             w_decide;
    logic [9:0]         r_spritex;
    logic [9:0]         r_spritey;
    logic [9:0]         w_next_x;
    logic [9:0]         w_next_y;
    logic [9:0]         w_x_stepped;
    logic [6:0]         r_vy;
    logic [6:0]         w_next_vy;
    logic [4:0]         r_timer;
    logic [4:0]         w_next_timer;
    logic [7:0]         r_health;
    logic [7:0]         w_dmg;
    logic               r_flip;
    logic               w_next_flip;
    logic               r_lock;
    logic               w_lock_set;
    logic               r_air_kick;
    logic               w_next_air_kick;
    logic [8:0]         r_pose;
    logic [8:0]         w_pose;
    logic               w_grounded;
    logic               w_punch_ok;
    logic               w_kick_ok;
    logic               w_go_left;
    logic               w_go_right;
    logic               w_land;
    logic signed [10:0] w_ysum;

    assign w_grounded = (r_state inside {S_IDLE, S_WALK, S_CROUCH, S_BLOCK});
    // Attack buttons stay masked after an attack until both are released
    assign w_punch_ok = btn_punch & ~r_lock;
    assign w_kick_ok  = btn_kick & ~r_lock;
    assign w_go_left  = btn_left & ~btn_right;
    assign w_go_right = btn_right & ~btn_left;
    assign w_ysum     = $signed({1'b0, r_spritey}) + $signed({{4{r_vy[6]}}, r_vy});
    assign w_land     = (w_ysum >= $signed({1'b0, GROUND_Y}));
    assign w_dmg      = (r_state == S_BLOCK) ? {2'b00, hit_damage[7:2]} : hit_damage;

    // Button priority decision used by the grounded states
    always_comb begin
        w_decide = S_IDLE;
        if (btn_up)                       w_decide = S_JUMP;
        else if (w_punch_ok && btn_down)  w_decide = S_CPUNCH;
        else if (w_punch_ok)              w_decide = S_PUNCH;
        else if (w_kick_ok)               w_decide = S_KICK;
        else if (btn_down)                w_decide = S_CROUCH;
        else if (btn_block)               w_decide = S_BLOCK;
        else if (w_go_left || w_go_right) w_decide = S_WALK;
    end

    // Saturating horizontal step; compared in 11 bits so the left edge never underflows
    always_comb begin
        w_x_stepped = r_spritex;
        if (w_go_left) begin
            if ({1'b0, r_spritex} < ({1'b0, X_MIN} + {7'd0, WALK_STEP}))
                w_x_stepped = X_MIN;
            else
                w_x_stepped = r_spritex - {6'd0, WALK_STEP};
        end else if (w_go_right) begin
            if (({1'b0, r_spritex} + {7'd0, WALK_STEP}) > {1'b0, X_MAX})
                w_x_stepped = X_MAX;
            else
                w_x_stepped = r_spritex + {6'd0, WALK_STEP};
        end
    end

    // FSM state register
    always_ff @(posedge vga_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next state: depleted health forces DEAD on any cycle, other moves only on tick
    always_comb begin
        w_next_state = r_state;
        if (r_state != S_DEAD && r_health == 8'd0) begin
            w_next_state = S_DEAD;
        end else if (frame_tick) begin
            case (r_state)
                S_IDLE, S_WALK, S_CROUCH, S_BLOCK: w_next_state = w_decide;
                S_JUMP:                   if (w_land) w_next_state = S_IDLE;
                S_PUNCH, S_KICK, S_CPUNCH: if (r_timer == 5'd0) w_next_state = S_IDLE;
                default:                  w_next_state = r_state;
            endcase
        end
    end

    // FSM outputs: pose decoded from the next state so flags register alongside it
    always_comb begin
        w_pose = '0;
        case (w_next_state)
            S_IDLE:   w_pose = 9'b1_0000_0000;
            S_WALK:   w_pose = 9'b1_0000_0100;
            S_CROUCH: w_pose = 9'b0_1000_0000;
            S_JUMP:   w_pose = w_next_air_kick ? 9'b0_0110_0000 : 9'b0_0100_0000;
            S_PUNCH:  w_pose = 9'b0_0001_0000;
            S_KICK:   w_pose = 9'b0_0010_0000;
            S_CPUNCH: w_pose = 9'b0_0000_1000;
            S_BLOCK:  w_pose = 9'b0_0000_0010;
            S_DEAD:   w_pose = 9'b0_0000_0001;
            default:  w_pose = '0;
        endcase
    end

    // Per-tick motion, timers and facing
    always_comb begin
        w_next_x        = r_spritex;
        w_next_y        = r_spritey;
        w_next_vy       = r_vy;
        w_next_timer    = r_timer;
        w_next_air_kick = r_air_kick;
        w_next_flip     = r_flip;
        w_lock_set      = 1'b0;
        if (frame_tick) begin
            case (r_state)
                S_IDLE, S_WALK, S_CROUCH, S_BLOCK: begin
                    w_next_flip = (opponent_x >= r_spritex);
                    case (w_next_state)
                        S_WALK: w_next_x = w_x_stepped;
                        S_JUMP: w_next_vy = 7'd0 - {1'b0, JUMP_V0};
                        S_PUNCH, S_CPUNCH: begin
                            w_next_timer = PUNCH_TICKS - 5'd1;
                            w_lock_set   = 1'b1;
                        end
                        S_KICK: begin
                            w_next_timer = KICK_TICKS - 5'd1;
                            w_lock_set   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_JUMP: begin
                    w_next_x = w_x_stepped;
                    if (w_land) begin
                        w_next_y        = GROUND_Y;
                        w_next_vy       = '0;
                        w_next_timer    = '0;
                        w_next_air_kick = 1'b0;
                    end else begin
                        w_next_y  = w_ysum[9:0];
                        w_next_vy = r_vy + {4'd0, GRAVITY};
`ifdef PLAYER_AIR_KICK_EN
                        // Air kick reuses the attack timer; physics keep running underneath
                        if (r_air_kick) begin
                            if (r_timer == 5'd0) w_next_air_kick = 1'b0;
                            else                 w_next_timer    = r_timer - 5'd1;
                        end else if (w_kick_ok) begin
                            w_next_air_kick = 1'b1;
                            w_next_timer    = KICK_TICKS - 5'd1;
                            w_lock_set      = 1'b1;
                        end
`endif
                    end
                end
                S_PUNCH, S_KICK, S_CPUNCH: begin
                    if (r_timer != 5'd0) w_next_timer = r_timer - 5'd1;
                end
                S_DEAD: begin
                    w_next_y        = GROUND_Y;
                    w_next_vy       = '0;
                    w_next_timer    = '0;
                    w_next_air_kick = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Motion, facing, attack lock and registered pose flags
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_spritex  <= START_X;
            r_spritey  <= GROUND_Y;
            r_vy       <= '0;
            r_timer    <= '0;
            r_air_kick <= 1'b0;
            r_flip     <= 1'b1;
            r_lock     <= 1'b0;
            r_pose     <= POSE_RESET;
        end else begin
            r_spritex  <= w_next_x;
            r_spritey  <= w_next_y;
            r_vy       <= w_next_vy;
            r_timer    <= w_next_timer;
            r_air_kick <= w_next_air_kick;
            r_flip     <= w_next_flip;
            r_pose     <= w_pose;
            if (!btn_punch && !btn_kick) r_lock <= 1'b0;
            else if (w_lock_set)         r_lock <= 1'b1;
        end
    end

    // Health: hits apply on any cycle, ignored once dead
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_health <= HEALTH_MAX;
        end else if (hit_valid && r_state != S_DEAD) begin
            r_health <= (w_dmg >= r_health) ? 8'd0 : r_health - w_dmg;
        end
    end

    assign spritex = r_spritex;
    assign spritey = r_spritey;
    assign flip    = r_flip;
    assign health  = r_health;
    assign {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead} = r_pose;

endmodule

// File: tb/tb_player_pose_ctrl.sv
// tb_player_pose_ctrl: scoreboard bench for player_pose_ctrl.
// Expected outputs are pushed when a frame step or hit is driven and popped once the DUT settles.
module tb_player_pose_ctrl;

    localparam logic [8:0] P_STAND  = 9'b1_0000_0000;
    localparam logic [8:0] P_CROUCH = 9'b0_1000_0000;
    localparam logic [8:0] P_JUMP   = 9'b0_0100_0000;
    localparam logic [8:0] P_KICK   = 9'b0_0010_0000;
    localparam logic [8:0] P_PUNCH  = 9'b0_0001_0000;
    localparam logic [8:0] P_CPUNCH = 9'b0_0000_1000;
    localparam logic [8:0] P_MOVE   = 9'b0_0000_0100;
    localparam logic [8:0] P_BLOCK  = 9'b0_0000_0010;
    localparam logic [8:0] P_DEAD   = 9'b0_0000_0001;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_punch = 1'b0, btn_kick = 1'b0, btn_block = 1'b0;
    logic [9:0] opponent_x = 10'd400;
    logic       hit_valid = 1'b0;
    logic [7:0] hit_damage = 8'd0;
    logic [9:0] spritex, spritey;
    logic       stand, crouch, jump, kick, punch, crouchpunch, move, block, dead, flip;
    logic [7:0] health;
    logic [8:0] obs_pose;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned pose;
        int unsigned flip;
        int unsigned health;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          m_x, m_y, m_health;
    logic [8:0]  m_pose;
    logic        m_flip;

    player_pose_ctrl dut (
        .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_punch(btn_punch), .btn_kick(btn_kick), .btn_block(btn_block),
        .opponent_x(opponent_x), .hit_valid(hit_valid), .hit_damage(hit_damage),
        .spritex(spritex), .spritey(spritey),
        .stand(stand), .crouch(crouch), .jump(jump), .kick(kick), .punch(punch),
        .crouchpunch(crouchpunch), .move(move), .block(block), .dead(dead), .flip(flip),
        .health(health)
    );

    assign obs_pose = {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead};

    always #5 vga_clk = ~vga_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = m_x; e.y = m_y; e.pose = m_pose; e.flip = m_flip; e.health = m_health;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string ctx);
        exp_t e;
        check_eq({ctx, "_sbdepth"}, sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_eq({ctx, "_x"},      32'(spritex),  e.x);
        check_eq({ctx, "_y"},      32'(spritey),  e.y);
        check_eq({ctx, "_pose"},   32'(obs_pose), e.pose);
        check_eq({ctx, "_flip"},   32'(flip),     e.flip);
        check_eq({ctx, "_health"}, 32'(health),   e.health);
    endtask

    // One frame tick; outputs sampled on the following falling edge
    task automatic step(input string ctx);
        @(negedge vga_clk);
        frame_tick = 1'b1;
        push_exp();
        @(negedge vga_clk);
        frame_tick = 1'b0;
        check_out(ctx);
    endtask

    task automatic hit(input string ctx, input logic [7:0] d);
        @(negedge vga_clk);
        hit_valid  = 1'b1;
        hit_damage = d;
        push_exp();
        @(negedge vga_clk);
        hit_valid = 1'b0;
        repeat (2) @(negedge vga_clk);
        check_out(ctx);
    endtask

    task automatic do_reset(input string ctx);
        {btn_left, btn_right, btn_up, btn_down, btn_punch, btn_kick, btn_block} = '0;
        @(negedge vga_clk);
        reset = 1'b1;
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
        m_x = 64; m_y = 300; m_health = 100; m_pose = P_STAND; m_flip = 1'b1;
        push_exp();
        check_out(ctx);
    endtask

    task automatic do_jump(input bit kick_at3);
        btn_up = 1'b1;
        m_pose = P_JUMP;
        m_flip = (opponent_x >= 10'(m_x));
        step($sformatf("jump%0d_entry", kick_at3));
        btn_up = 1'b0;
        for (int n = 1; n <= 29; n++) begin
            if (kick_at3 && n == 3) btn_kick = 1'b1;
            m_y = 300 - 14 * n + (n * (n - 1)) / 2;
            if (n == 29) begin
                m_pose = P_STAND;
            end else begin
                m_pose = P_JUMP;
`ifdef PLAYER_AIR_KICK_EN
                if (kick_at3 && n >= 3 && n <= 14) m_pose = P_JUMP | P_KICK;
`endif
            end
            step($sformatf("jump%0d_n%0d", kick_at3, n));
            btn_kick = 1'b0;
        end
    endtask

    task automatic do_attack(input string nm, input logic p, input logic k, input logic d,
                             input logic [8:0] act, input logic [8:0] after,
                             input int n_act, input int n_tot);
        btn_punch = p; btn_kick = k; btn_down = d;
        for (int t = 0; t < n_tot; t++) begin
            if (t < n_act)       m_pose = act;
            else if (t == n_act) m_pose = P_STAND;
            else                 m_pose = after;
            step($sformatf("%s_t%0d", nm, t));
        end
        btn_punch = 1'b0; btn_kick = 1'b0; btn_down = 1'b0;
        m_pose = P_STAND;
        step({nm, "_rel"});
    endtask

    initial begin
        do_reset("reset");
        for (int i = 0; i < 5; i++) step($sformatf("idle%0d", i));

        // Walk right into the right clamp, facing away from an opponent at x=0
        opponent_x = 10'd0;
        btn_right  = 1'b1;
        m_pose     = P_STAND | P_MOVE;
        for (int i = 0; i < 200; i++) begin
            m_flip = (opponent_x >= 10'(m_x));
            m_x    = (m_x + 3 > 512) ? 512 : m_x + 3;
            step($sformatf("walkR%0d", i));
        end
        btn_right = 1'b0;
        m_pose = P_STAND;
        m_flip = (opponent_x >= 10'(m_x));
        step("walkR_stop");

        // Walk left into the left clamp; no wrap below zero
        opponent_x = 10'd400;
        btn_left   = 1'b1;
        m_pose     = P_STAND | P_MOVE;
        for (int i = 0; i < 200; i++) begin
            m_flip = (opponent_x >= 10'(m_x));
            m_x    = (m_x < 3) ? 0 : m_x - 3;
            step($sformatf("walkL%0d", i));
        end

        // Left and right together cancel
        btn_right = 1'b1;
        m_pose = P_STAND;
        for (int i = 0; i < 3; i++) begin
            m_flip = (opponent_x >= 10'(m_x));
            step($sformatf("bothLR%0d", i));
        end
        btn_left = 1'b0; btn_right = 1'b0;

        do_jump(1'b0);
        do_jump(1'b1);

        do_attack("punch",  1'b1, 1'b0, 1'b0, P_PUNCH,  P_STAND,  8,  20);
        do_attack("kick",   1'b0, 1'b1, 1'b0, P_KICK,   P_STAND,  12, 16);
        do_attack("cpunch", 1'b1, 1'b0, 1'b1, P_CPUNCH, P_CROUCH, 8,  12);

        // Blocked hit deals a quarter of the damage
        btn_block = 1'b1;
        m_pose = P_BLOCK;
        step("block_entry");
        m_health = 100 - 40 / 4;
        hit("block_hit40", 8'd40);
        btn_block = 1'b0;
        m_pose = P_STAND;
        step("block_rel");
        m_health = m_health - 30;
        hit("idle_hit30", 8'd30);

        // Lethal hit coincident with a walking tick: step happens, then DEAD
        btn_right = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b1;
        hit_valid  = 1'b1;
        hit_damage = 8'd200;
        m_x = m_x + 3; m_health = 0; m_pose = P_DEAD;
        push_exp();
        @(negedge vga_clk);
        frame_tick = 1'b0;
        hit_valid  = 1'b0;
        repeat (2) @(negedge vga_clk);
        check_out("lethal_tick");

        // DEAD is sticky through buttons, ticks and hits
        btn_up = 1'b1; btn_punch = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("dead%0d", i));
        hit("dead_hit", 8'd50);

        do_reset("reset_from_dead");
        step("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
